// File: rtl/switch_merge.sv
// Merges the A (low address) and B (high address) return channels into one registered valid/ready stream.
// Optional ADDR_CHECK_EN: drops and counts entries whose address belongs to the other channel.
`timescale 1ns/1ps
module switch_merge #(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] ADDR_DIV   = 8'h3F,
   parameter int unsigned           FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  vld_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic [DATA_WIDTH-1:0] data_a,
   output logic                  rdy_a,
   input  logic                  vld_b,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   input  logic [DATA_WIDTH-1:0] data_b,
   output logic                  rdy_b,
   output logic                  vld,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  src,
   input  logic                  rdy,
   output logic [7:0]            err_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef logic [AW:0] ptr_t;

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ADDR_DIV == '1) begin : g_bad_cfg
      $error("switch_merge: FIFO_DEPTH must be a power of 2 >= 2 and ADDR_DIV must leave room for channel B");
   end

   logic [ADDR_WIDTH-1:0] r_mem_addr [2][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_data [2][FIFO_DEPTH];
   ptr_t                  r_wp [2];
   ptr_t                  r_rp [2];

   logic                  r_vld;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_src;
   logic                  r_last;

   logic                  w_vld_in  [2];
   logic [ADDR_WIDTH-1:0] w_addr_in [2];
   logic [DATA_WIDTH-1:0] w_data_in [2];
   logic                  w_ok      [2];
   logic                  w_full    [2];
   logic                  w_empty   [2];
   logic                  w_wr      [2];
   logic                  w_pop     [2];
   logic                  w_load;
   logic                  w_gnt;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   always_comb begin
      w_vld_in[0]  = vld_a;
      w_addr_in[0] = addr_a;
      w_data_in[0] = data_a;
      w_vld_in[1]  = vld_b;
      w_addr_in[1] = addr_b;
      w_data_in[1] = data_b;
      for (int unsigned ch = 0; ch < 2; ch++) begin
         w_empty[ch] = (r_wp[ch] == r_rp[ch]);
         w_full[ch]  = (r_wp[ch][AW] != r_rp[ch][AW]) &&
                       (r_wp[ch][AW-1:0] == r_rp[ch][AW-1:0]);
         w_ok[ch]    = 1'b1;
`ifdef ADDR_CHECK_EN
         w_ok[ch]    = (ch == 0) ? (w_addr_in[ch] <= ADDR_DIV) : (w_addr_in[ch] > ADDR_DIV);
`endif
         w_wr[ch]    = rstn && w_vld_in[ch] && !w_full[ch] && w_ok[ch];
      end
      w_gnt    = w_empty[0] ? 1'b1 : (w_empty[1] ? 1'b0 : !r_last);
      w_load   = (!r_vld || rdy) && !(w_empty[0] && w_empty[1]);
      w_pop[0] = w_load && !w_gnt;
      w_pop[1] = w_load && w_gnt;
   end

   assign rdy_a = rstn && !w_full[0];
   assign rdy_b = rstn && !w_full[1];

   always_ff @(posedge clk) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
         if (w_wr[ch]) begin
            r_mem_addr[ch][r_wp[ch][AW-1:0]] <= w_addr_in[ch];
            r_mem_data[ch][r_wp[ch][AW-1:0]] <= w_data_in[ch];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned ch = 0; ch < 2; ch++) begin
            r_wp[ch] <= '0;
            r_rp[ch] <= '0;
         end
         r_vld  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
         r_src  <= 1'b0;
         r_last <= 1'b1;
      end else begin
         for (int unsigned ch = 0; ch < 2; ch++) begin
            if (w_wr[ch])  r_wp[ch] <= r_wp[ch] + 1'b1;
            if (w_pop[ch]) r_rp[ch] <= r_rp[ch] + 1'b1;
         end
         if (w_load) begin
            r_vld  <= 1'b1;
            r_addr <= r_mem_addr[w_gnt][r_rp[w_gnt][AW-1:0]];
            r_data <= r_mem_data[w_gnt][r_rp[w_gnt][AW-1:0]];
            r_src  <= w_gnt;
            r_last <= w_gnt;
         end else if (r_vld && rdy) begin
            r_vld  <= 1'b0;
         end
      end
   end

   assign vld  = r_vld;
   assign addr = r_addr;
   assign data = r_data;
   assign src  = r_src;

`ifdef ADDR_CHECK_EN
   logic [7:0] r_err_cnt;
   logic [1:0] w_drop_n;
   logic [8:0] w_err_sum;

   // Both channels can drop in the same cycle, so the counter may step by 2.
   always_comb begin
      w_drop_n  = {1'b0, rstn && w_vld_in[0] && !w_full[0] && !w_ok[0]} +
                  {1'b0, rstn && w_vld_in[1] && !w_full[1] && !w_ok[1]};
      w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_drop_n};
   end

   always_ff @(posedge clk) begin
      if (!rstn)                   r_err_cnt <= '0;
      else if (w_err_sum > 9'h0FF) r_err_cnt <= '1;
      else                         r_err_cnt <= w_err_sum[7:0];
   end

   assign err_cnt = r_err_cnt;
`else
   assign err_cnt = '0;
`endif

endmodule

// File: doc/switch_merge.md
Name: switch_merge

Overview:
- Return-path companion to the address switch: merges the two routed channels (A = low address range, B = high address range) back into one addr/data stream.
- Each channel is buffered in its own small FIFO. A round-robin arbiter drains both FIFOs into a registered valid/ready output.
- Sits downstream of the A/B endpoints; feeds the single upstream consumer.

Parameters:
- ADDR_WIDTH, 8, address width of all channels
- DATA_WIDTH, 16, data width of all channels
- ADDR_DIV, 8'h3F, highest address belonging to channel A; channel B owns ADDR_DIV+1 and above
- FIFO_DEPTH, 4, entries per input FIFO; power of 2, minimum 2

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  synchronous active-low reset
- vld_a  in  1  channel A entry valid
- addr_a  in  ADDR_WIDTH  channel A address
- data_a  in  DATA_WIDTH  channel A data
- rdy_a  out  1  channel A FIFO can accept
- vld_b  in  1  channel B entry valid
- addr_b  in  ADDR_WIDTH  channel B address
- data_b  in  DATA_WIDTH  channel B data
- rdy_b  out  1  channel B FIFO can accept
- vld  out  1  merged output valid
- addr  out  ADDR_WIDTH  merged address
- data  out  DATA_WIDTH  merged data
- src  out  1  source of the current output entry: 0 = A, 1 = B
- rdy  in  1  consumer accepts the output entry
- err_cnt  out  8  misrouted-entry count (Optional Feature); 0 without the macro

Behaviour:
- Reset (rstn low at a rising clk edge):
  - both FIFOs empty; vld, addr, data, src, err_cnt = 0
  - last_grant = B, so A wins the first tie
  - rdy_a and rdy_b are 0 while rstn is low.
- Input acceptance:
  - rdy_x = rstn && !full_x, combinational from the FIFO count.
  - An entry is written at the edge where vld_x && rdy_x.
  - A full FIFO never accepts a write, even if an entry is read from it in the same cycle (no fall-through).
- Output register:
  - Loads when (!vld || rdy) and at least one FIFO is non-empty. The head entry is popped in the same edge.
  - Otherwise, if vld && rdy, vld clears to 0.
  - While vld && !rdy: vld, addr, data and src hold stable.
- Arbitration:
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the channel opposite last_grant.
  - last_grant updates only on an actual pop.
  - Continuous back-to-back traffic on both channels alternates A, B, A, B.
- Latency and throughput:
  - Entry accepted at edge k into an empty FIFO with the output free: vld high after edge k+1.
  - Sustained throughput is 1 entry per cycle when rdy is held high.
- Ordering: per-channel FIFO order is preserved; there is no ordering guarantee across channels.
- Reset mid-operation: all buffered and output entries are discarded. No partial entry is ever presented.

Optional Feature:
- ADDR_CHECK_EN defined:
  - An entry on A with addr > ADDR_DIV, or on B with addr <= ADDR_DIV, is accepted (rdy semantics unchanged) but not written to the FIFO.
  - err_cnt increments by 1 per dropped entry and saturates at 8'hFF.
- ADDR_CHECK_EN undefined: every accepted entry is forwarded unchecked; err_cnt tied to 0.

Test Plan:
- Reset, then A writes addr 8'h10 data 16'hAAAA with rdy=1 → two edges later vld=1, addr=8'h10, data=16'hAAAA, src=0; next cycle vld=0.
- A and B both write 4 entries at the same time (A 8'h00..8'h03, B 8'h40..8'h43), rdy=1 → output order A0, B40, A1, B41, A2, B42, A3, B43.
- Hold rdy=0, write 5 entries to A with FIFO_DEPTH=4 → rdy_a=0 after 4 entries in the FIFO plus 1 in the output register. Output holds addr/data stable. Release rdy → all entries emerge in order and rdy_a returns to 1.
- Stream 8 entries on B only with rdy toggling 1,0,1,0 → no loss or duplication, and each entry appears exactly on a vld&&rdy edge.
- ADDR_CHECK_EN build: A writes addr 8'h80, B writes addr 8'h3F → neither appears on the output and err_cnt=2. Force 300 bad writes → err_cnt=8'hFF.
- Assert rstn=0 for one edge with 3 entries buffered and vld=1 → next cycle vld=0, FIFOs empty, rdy_a=rdy_b=1 once rstn=1.
